// File: rtl/ethernet_ipv4_csum_insert_if.sv
// AXI4-Stream bundle used on both sides of the IPv4 checksum inserter.
// The master drives payload and valid. The slave drives ready.
interface ethernet_ipv4_csum_insert_if #(
  parameter int DATA_BYTES = 4
) ();
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tstrb;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tstrb, tlast, tvalid, input tready);
  modport slave  (input tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/ethernet_ipv4_csum_insert.sv
// Buffers the first 9 beats of each frame and fills in the IPv4 header checksum
// (bytes 24-25) when the frame is option-less IPv4. The rest of the frame streams through.
module ethernet_ipv4_csum_insert #(
  parameter int C_AXIS_TDATA_NUM_BYTES = 4,  // only 4 is supported
  parameter int C_CSUM_ENABLE          = 1
) (
  input  logic                               AXIS_ACLK,
  input  logic                               AXIS_ARESETN,
  ethernet_ipv4_csum_insert_if.slave         s_axis,
  ethernet_ipv4_csum_insert_if.master        m_axis
);

  localparam int W  = 8 * C_AXIS_TDATA_NUM_BYTES;
  localparam int NB = 9;

  typedef enum logic [1:0] {COLLECT, CALC, DRAIN, STREAM} state_t;

  state_t                              state, state_nxt;
  logic [W-1:0]                        data_buf [NB];
  logic [C_AXIS_TDATA_NUM_BYTES-1:0]   strb_buf [NB];
  logic [3:0]                          wr_idx, rd_idx, beat_cnt;
  logic                                last_seen;
  logic [19:0]                         acc;
  logic [16:0]                         contrib;
  logic [16:0]                         fold1, fold2;
  logic [15:0]                         csum;
  logic                                eligible;
  logic                                s_accept;
  logic                                rd_last;
  logic                                collect_end;

  assign s_accept    = s_axis.tvalid && s_axis.tready;
  assign rd_last     = (rd_idx == beat_cnt - 4'd1);
  assign collect_end = s_axis.tlast || (wr_idx == 4'd8);

  // Big-endian header words carried by the incoming beat. Word 12 (the checksum field) is skipped.
  always_comb begin
    contrib = '0;
    case (wr_idx)
      4'd3:                contrib = {1'b0, s_axis.tdata[23:16], s_axis.tdata[31:24]};
      4'd4, 4'd5, 4'd7:    contrib = {1'b0, s_axis.tdata[7:0],   s_axis.tdata[15:8]}
                                   + {1'b0, s_axis.tdata[23:16], s_axis.tdata[31:24]};
      4'd6:                contrib = {1'b0, s_axis.tdata[23:16], s_axis.tdata[31:24]};
      4'd8:                contrib = {1'b0, s_axis.tdata[7:0],   s_axis.tdata[15:8]};
      default:             contrib = '0;
    endcase
  end

  // Two end-around-carry folds are enough for a 20-bit sum of nine 16-bit words.
  always_comb begin
    fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    fold2 = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
    csum  = ~fold2[15:0];
  end

  assign eligible = (C_CSUM_ENABLE != 0)
                 && (data_buf[3][7:0]   == 8'h08)
                 && (data_buf[3][15:8]  == 8'h00)
                 && (data_buf[3][23:16] == 8'h45)
                 && (beat_cnt == 4'd9)
                 && (!last_seen || (strb_buf[8][1:0] == 2'b11));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) state <= COLLECT;
    else               state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tstrb  = '0;
    m_axis.tlast  = 1'b0;
    case (state)
      COLLECT: begin
        s_axis.tready = AXIS_ARESETN;
        if (s_axis.tvalid && collect_end) state_nxt = CALC;
      end
      CALC: state_nxt = DRAIN;
      DRAIN: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = data_buf[rd_idx];
        m_axis.tstrb  = strb_buf[rd_idx];
        m_axis.tlast  = last_seen && rd_last;
        if (m_axis.tready && rd_last) state_nxt = last_seen ? COLLECT : STREAM;
      end
      STREAM: begin
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tstrb  = s_axis.tstrb;
        m_axis.tlast  = s_axis.tlast;
        s_axis.tready = m_axis.tready;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      beat_cnt  <= '0;
      last_seen <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        COLLECT: if (s_accept) begin
          // Beat 0 restarts the sum, so nothing from the previous frame carries over.
          acc <= ((wr_idx == 4'd0) ? 20'd0 : acc) + {3'd0, contrib};
          if (collect_end) begin
            beat_cnt  <= wr_idx + 4'd1;
            last_seen <= s_axis.tlast;
            wr_idx    <= '0;
          end else begin
            wr_idx <= wr_idx + 4'd1;
          end
        end
        CALC:    rd_idx <= '0;
        DRAIN:   if (m_axis.tready) rd_idx <= rd_idx + 4'd1;
        default: ;
      endcase
    end
  end

  // NOTE: the frame buffer has no reset; its contents are only read after being written.
  always_ff @(posedge AXIS_ACLK) begin
    if (state == COLLECT && s_accept) begin
      data_buf[wr_idx] <= s_axis.tdata;
      strb_buf[wr_idx] <= s_axis.tstrb;
    end else if (state == CALC && eligible) begin
      data_buf[6][15:0] <= {csum[7:0], csum[15:8]};
    end
  end

endmodule

// File: tb/tb_ethernet_ipv4_csum_insert.sv
// Randomized self-checking bench for ethernet_ipv4_csum_insert. A byte-level frame model
// predicts every output beat, and the monitor checks latency and stall stability.
module tb_ethernet_ipv4_csum_insert;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  ethernet_ipv4_csum_insert_if #(.DATA_BYTES(4)) s_if ();
  ethernet_ipv4_csum_insert_if #(.DATA_BYTES(4)) m_if ();

  ethernet_ipv4_csum_insert #(
    .C_AXIS_TDATA_NUM_BYTES(4),
    .C_CSUM_ENABLE(1)
  ) dut (
    .AXIS_ACLK   (clk),
    .AXIS_ARESETN(rst_n),
    .s_axis      (s_if),
    .m_axis      (m_if)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  logic [31:0] exp_d [$];
  logic [3:0]  exp_s [$];
  logic        exp_l [$];
  logic [7:0]  fb [$];
  int          fr_len;
  bit          rand_ready = 1'b0;
  bit          hold_ready = 1'b1;
  bit          chk_b861   = 1'b0;

  logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                           8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] beat_strb(input int b, input int nb);
    int rem;
    if (b < nb - 1) return 4'hF;
    rem = fr_len - 4 * b;
    return 4'((1 << rem) - 1);
  endfunction

  // kind: 0 random bytes, 1 IPv4 ethertype/version, 2 reference header, 3 reference header with FFFF checksum
  task automatic make_frame(input int len, input int kind);
    int nb;
    fb.delete();
    fr_len = len;
    nb = (len + 3) / 4;
    for (int i = 0; i < nb * 4; i++) fb.push_back(8'($urandom));
    if (kind >= 1 && len > 14) begin
      fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45;
    end
    if (kind >= 2) for (int i = 0; i < 20; i++) fb[14 + i] = hdr[i];
    if (kind == 3) begin fb[24] = 8'hFF; fb[25] = 8'hFF; end
  endtask

  // Expected output of a frame: checksum over bytes 14..33 with bytes 24..25 as zero.
  task automatic model_frame();
    logic [7:0]  ob [$];
    logic [31:0] sum;
    logic [15:0] c;
    bit          elig;
    int          nb;
    ob = fb;
    elig = (fr_len >= 34) && fb[12] == 8'h08 && fb[13] == 8'h00 && fb[14] == 8'h45;
    if (elig) begin
      sum = 0;
      for (int i = 14; i < 34; i += 2)
        if (i != 24) sum += {16'd0, fb[i], fb[i + 1]};
      while (sum[31:16] != 0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
      c = ~sum[15:0];
      ob[24] = c[15:8];
      ob[25] = c[7:0];
    end
    nb = fb.size() / 4;
    for (int b = 0; b < nb; b++) begin
      exp_d.push_back({ob[4*b+3], ob[4*b+2], ob[4*b+1], ob[4*b]});
      exp_s.push_back(beat_strb(b, nb));
      exp_l.push_back(b == nb - 1);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_frame();
    int nb;
    bit hs;
    int t;
    model_frame();
    nb = fb.size() / 4;
    for (int b = 0; b < nb; b++) begin
      s_if.tdata  = {fb[4*b+3], fb[4*b+2], fb[4*b+1], fb[4*b]};
      s_if.tstrb  = beat_strb(b, nb);
      s_if.tlast  = (b == nb - 1);
      s_if.tvalid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        hs = s_if.tready;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 2000);
      if (!hs) begin
        check("src_timeout", 32'(hs), 32'd1);
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_d.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_done", exp_d.size(), 32'd0);
  endtask

  // Downstream ready generator.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    bit          pend = 1'b0;
    logic [31:0] pd;
    logic [3:0]  ps;
    logic        pl;
    int          s_idx = 0;
    int          m_idx = 0;
    bit          lat_arm = 1'b0;
    int          lat_ref = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; s_idx = 0; m_idx = 0; lat_arm = 1'b0;
        continue;
      end
      if (pend) begin
        check("hold_valid", 32'(m_if.tvalid), 32'd1);
        check("hold_data",  m_if.tdata, pd);
        check("hold_strb",  32'(m_if.tstrb), 32'(ps));
        check("hold_last",  32'(m_if.tlast), 32'(pl));
      end
      pend = m_if.tvalid && !m_if.tready;
      pd = m_if.tdata; ps = m_if.tstrb; pl = m_if.tlast;
      if (lat_arm && m_if.tvalid) begin
        check("latency", 32'(cyc - lat_ref), 32'd2);
        lat_arm = 1'b0;
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_d.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          check("out_data", m_if.tdata, exp_d.pop_front());
          check("out_strb", 32'(m_if.tstrb), 32'(exp_s.pop_front()));
          check("out_last", 32'(m_if.tlast), 32'(exp_l.pop_front()));
        end
        if (chk_b861 && m_idx == 6) check("csum_field", {16'd0, m_if.tdata[15:0]}, 32'h0000_61B8);
        m_idx = m_if.tlast ? 0 : m_idx + 1;
      end
      if (s_if.tvalid && s_if.tready) begin
        if (s_idx <= 8 && (s_idx == 8 || s_if.tlast)) begin
          lat_arm = 1'b1;
          lat_ref = cyc;
        end
        s_idx = s_if.tlast ? 0 : s_idx + 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tdata",  m_if.tdata, 32'd0);
    check("rst_tstrb",  32'(m_if.tstrb), 32'd0);
    check("rst_tlast",  32'(m_if.tlast), 32'd0);
    check("rst_tready", 32'(s_if.tready), 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("tready_after_rst", 32'(s_if.tready), 32'd1);
    @(posedge clk); #1;

    // Reference header, full-rate sink, then same with FFFF in the checksum field.
    chk_b861 = 1'b1;
    make_frame(64, 2); send_frame(); wait_drain();
    make_frame(64, 3); send_frame(); wait_drain();
    chk_b861 = 1'b0;

    // Not IPv4 ethertype, and IHL != 5.
    make_frame(64, 2); fb[12] = 8'h86; fb[13] = 8'hDD; send_frame(); wait_drain();
    make_frame(64, 2); fb[14] = 8'h46; send_frame(); wait_drain();

    // Short 5-beat frame with two valid bytes in the last beat, then a valid frame.
    make_frame(18, 1); send_frame(); wait_drain();
    chk_b861 = 1'b1;
    make_frame(64, 2); send_frame(); wait_drain();

    // Reference frame with a toggling sink.
    rand_ready = 1'b1;
    make_frame(64, 2); send_frame(); wait_drain();
    rand_ready = 1'b0;

    // Reset while draining: outputs drop at once, and the frame is discarded.
    hold_ready = 1'b0;
    @(posedge clk); #1;
    make_frame(36, 2); send_frame();
    t = 0;
    while (!m_if.tvalid && t < 100) begin @(negedge clk); t++; end
    check("drain_reached", 32'(m_if.tvalid), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_tdata",  m_if.tdata, 32'd0);
    check("midrst_tstrb",  32'(m_if.tstrb), 32'd0);
    check("midrst_tlast",  32'(m_if.tlast), 32'd0);
    check("midrst_tready", 32'(s_if.tready), 32'd0);
    exp_d.delete(); exp_s.delete(); exp_l.delete();
    hold_ready = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("tready_after_midrst", 32'(s_if.tready), 32'd1);
    @(posedge clk); #1;
    make_frame(64, 2); send_frame(); wait_drain();

    // Three back-to-back reference frames.
    make_frame(64, 2); send_frame();
    make_frame(64, 2); send_frame();
    make_frame(64, 2); send_frame();
    wait_drain();
    chk_b861 = 1'b0;

    // Random frames: lengths that cluster around the 9-beat boundary, random sink.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(30, 40)) : int'($urandom_range(1, 90));
      make_frame(len, int'($urandom_range(0, 1)) + ((f % 5 == 0 && len >= 34) ? 1 : 0));
      send_frame();
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
